mux_arb_n: RTL and testbench

//  Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake on every input and on the output.
//  Two modes: explicit select, as the datapath operand muxes use, or round-robin arbitration between channels.

---
 rtl/mux_arb_n_pkg.sv | 21 ++
 rtl/mux_arb_n_arbiter.sv | 45 ++++
 rtl/mux_arb_n.sv | 97 +++++++++
 tb/tb_mux_arb_n.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_n_pkg.sv
// Shared types and helpers for the N-input registered mux / arbiter.
package mux_pkg;

    // Steering mode: explicit select or round-robin grant
    typedef enum logic {
        MUX_SEL,
        MUX_RR
    } mux_mode_e;

    // Output register occupancy
    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } out_state_e;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_n_arbiter.sv
// Round-robin arbiter: searches upward from the slot after the last winner.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] search_idx;
    logic             found;

    // Pick the first requester at ptr+1, ptr+2, ... wrapping modulo N
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        search_idx  = '0;
        found       = 1'b0;
        for (int i = 1; i <= N; i++) begin
            search_idx = IDX_W'((int'(ptr) + i) % N);
            if (!found && i_req[search_idx]) begin
                found                = 1'b1;
                o_grant[search_idx]  = 1'b1;
                o_grant_idx          = search_idx;
            end
        end
    end

    // Pointer remembers the last accepted winner; it starts at N-1 so channel 0 wins first
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= IDX_W'(N - 1);
        end else if (i_advance && (|o_grant)) begin
            ptr <= o_grant_idx;
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-input registered multiplexer with valid/ready on every channel and on the output.
// One cycle of latency, full throughput, data held while the consumer stalls.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter int        WIDTH = 64,
    parameter int        N     = 4,
    parameter mux_mode_e MODE  = MUX_SEL,
    localparam int       SEL_W = clog2_min1(N)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [SEL_W-1:0]        i_select,
    input  logic [N-1:0]            i_valid,
    input  logic [N-1:0][WIDTH-1:0] i_data,
    output logic [N-1:0]            o_ready,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_data,
    output logic [SEL_W-1:0]        o_src,
    input  logic                    i_ready
);

    localparam logic [N-1:0] ONE = N'(1);

    out_state_e       state;
    out_state_e       state_next;
    logic             can_load;
    logic             grant_exists;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer_in;
    logic             xfer_out;

    assign o_valid  = (state == ST_FULL);
    assign can_load = !o_valid || i_ready;
    assign xfer_out = o_valid && i_ready;

    generate
        if (MODE == MUX_RR) begin : g_rr
            logic [N-1:0] arb_grant;
            logic         unused_select;

            rr_arbiter_n #(
                .N     (N),
                .IDX_W (SEL_W)
            ) u_arb (
                .i_clk       (i_clk),
                .i_rst_n     (i_rst_n),
                .i_req       (i_valid),
                .i_advance   (xfer_in),
                .o_grant     (arb_grant),
                .o_grant_idx (grant_idx)
            );

            assign grant_exists  = |arb_grant;
            assign unused_select = ^i_select;
        end else begin : g_sel
            // Out-of-range selects (non power-of-two N) grant nobody
            assign grant_idx    = i_select;
            assign grant_exists = (int'(i_select) < N);
        end
    endgenerate

    // No handshake is offered while reset is held, so the first accept lands on the edge after release
    assign o_ready = (i_rst_n && can_load && grant_exists) ? (ONE << grant_idx) : '0;
    assign xfer_in = |(o_ready & i_valid);

    // Occupancy register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Fill on accept; empty only when draining without a replacement word
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (xfer_in) state_next = ST_FULL;
            ST_FULL:  if (xfer_out && !xfer_in) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Capture only the granted channel's word and remember where it came from
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_src  <= '0;
        end else if (xfer_in) begin
            o_data <= i_data[grant_idx];
            o_src  <= grant_idx;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: a select-mode and a round-robin instance with N=4,
// plus a select-mode instance with N=3 for the out-of-range select case.
module tb_mux_arb_n;
    import mux_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  src;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [1:0]       s_select;
    logic [3:0]       s_valid;
    logic [3:0][63:0] s_data;
    logic [3:0]       s_oready;
    logic             s_ovalid;
    logic [63:0]      s_odata;
    logic [1:0]       s_osrc;
    logic             s_iready;

    logic [1:0]       r_select;
    logic [3:0]       r_valid;
    logic [3:0][63:0] r_data;
    logic [3:0]       r_oready;
    logic             r_ovalid;
    logic [63:0]      r_odata;
    logic [1:0]       r_osrc;
    logic             r_iready;

    logic [1:0]       t_select;
    logic [2:0]       t_valid;
    logic [2:0][63:0] t_data;
    logic [2:0]       t_oready;
    logic             t_ovalid;
    logic [63:0]      t_odata;
    logic [1:0]       t_osrc;
    logic             t_iready;

    exp_t q_sel[$];
    exp_t q_rr[$];
    exp_t q_odd[$];

    int n_cmp;
    int n_bad;

    mux_arb_n #(.WIDTH(64), .N(4), .MODE(MUX_SEL)) u_sel (
        .i_clk(clk), .i_rst_n(rst_n), .i_select(s_select), .i_valid(s_valid),
        .i_data(s_data), .o_ready(s_oready), .o_valid(s_ovalid), .o_data(s_odata),
        .o_src(s_osrc), .i_ready(s_iready)
    );

    mux_arb_n #(.WIDTH(64), .N(4), .MODE(MUX_RR)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_select(r_select), .i_valid(r_valid),
        .i_data(r_data), .o_ready(r_oready), .o_valid(r_ovalid), .o_data(r_odata),
        .o_src(r_osrc), .i_ready(r_iready)
    );

    mux_arb_n #(.WIDTH(64), .N(3), .MODE(MUX_SEL)) u_odd (
        .i_clk(clk), .i_rst_n(rst_n), .i_select(t_select), .i_valid(t_valid),
        .i_data(t_data), .o_ready(t_oready), .o_valid(t_ovalid), .o_data(t_odata),
        .o_src(t_osrc), .i_ready(t_iready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_sel(input logic [63:0] d, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        q_sel.push_back(e);
    endtask

    task automatic push_rr(input logic [63:0] d, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        q_rr.push_back(e);
    endtask

    task automatic push_odd(input logic [63:0] d, input logic [1:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        q_odd.push_back(e);
    endtask

    // Compare every word the consumer takes against the oldest expected word
    task automatic scoreboard_all();
        exp_t e;
        if (s_ovalid && s_iready) begin
            if (q_sel.size() == 0) check_output("sel_unexpected_word", 64'(q_sel.size()), 64'd1);
            else begin
                e = q_sel.pop_front();
                check_output("sel_data", s_odata, e.data);
                check_output("sel_src", 64'(s_osrc), 64'(e.src));
            end
        end
        if (r_ovalid && r_iready) begin
            if (q_rr.size() == 0) check_output("rr_unexpected_word", 64'(q_rr.size()), 64'd1);
            else begin
                e = q_rr.pop_front();
                check_output("rr_data", r_odata, e.data);
                check_output("rr_src", 64'(r_osrc), 64'(e.src));
            end
        end
        if (t_ovalid && t_iready) begin
            if (q_odd.size() == 0) check_output("odd_unexpected_word", 64'(q_odd.size()), 64'd1);
            else begin
                e = q_odd.pop_front();
                check_output("odd_data", t_odata, e.data);
                check_output("odd_src", 64'(t_osrc), 64'(e.src));
            end
        end
    endtask

    // One clock: settle, score consumed words, advance to just after the next edge
    task automatic apply_stimulus();
        #1;
        scoreboard_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        s_select = 2'd0; s_valid = 4'hF; s_iready = 1'b0;
        r_select = 2'd0; r_valid = 4'hF; r_iready = 1'b0;
        t_select = 2'd0; t_valid = 3'h7; t_iready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_data[k] = 64'h5000 + 64'(k);
            r_data[k] = 64'h1000 + 64'(k);
        end
        for (int k = 0; k < 3; k++) t_data[k] = 64'h7000 + 64'(k);

        // Reset held with every channel valid
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_sel_valid", 64'(s_ovalid), 64'd0);
        check_output("rst_sel_data", s_odata, 64'd0);
        check_output("rst_sel_src", 64'(s_osrc), 64'd0);
        check_output("rst_sel_ready", 64'(s_oready), 64'd0);
        check_output("rst_rr_valid", 64'(r_ovalid), 64'd0);
        check_output("rst_rr_ready", 64'(r_oready), 64'd0);

        // Release and steer channel 2
        rst_n     = 1'b1;
        r_valid   = 4'h0;
        t_valid   = 3'h0;
        s_select  = 2'd2;
        s_valid   = 4'b0100;
        s_data[2] = 64'hDEAD_BEEF;
        s_iready  = 1'b1;
        #1;
        check_output("sel_ready_ch2", 64'(s_oready), 64'b0100);
        push_sel(64'hDEAD_BEEF, 2'd2);
        apply_stimulus();
        check_output("sel_latency_valid", 64'(s_ovalid), 64'd1);
        check_output("sel_latency_src", 64'(s_osrc), 64'd2);
        s_valid = 4'b0000;
        apply_stimulus();
        check_output("sel_drained", 64'(s_ovalid), 64'd0);

        // Back-pressure: fill, then stall five cycles with a new word waiting
        s_iready  = 1'b0;
        s_select  = 2'd1;
        s_valid   = 4'b0010;
        s_data[1] = 64'hA1A1_0001;
        #1;
        check_output("bp_ready_empty", 64'(s_oready), 64'b0010);
        push_sel(64'hA1A1_0001, 2'd1);
        apply_stimulus();
        s_select  = 2'd3;
        s_valid   = 4'b1000;
        s_data[3] = 64'hB3B3_0003;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_output("bp_ready_stall", 64'(s_oready), 64'd0);
            check_output("bp_data_stable", s_odata, 64'hA1A1_0001);
            check_output("bp_valid_stable", 64'(s_ovalid), 64'd1);
            apply_stimulus();
        end
        s_iready = 1'b1;
        #1;
        check_output("bp_ready_release", 64'(s_oready), 64'b1000);
        push_sel(64'hB3B3_0003, 2'd3);
        apply_stimulus();
        check_output("bp_no_bubble", 64'(s_ovalid), 64'd1);
        check_output("bp_new_src", 64'(s_osrc), 64'd3);

        // Back-to-back words on channel 0, one per cycle
        s_select = 2'd0;
        s_valid  = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            s_data[0] = 64'hC0C0_0000 + 64'(c);
            push_sel(64'hC0C0_0000 + 64'(c), 2'd0);
            apply_stimulus();
        end
        s_valid = 4'b0000;
        apply_stimulus();
        check_output("b2b_drained", 64'(s_ovalid), 64'd0);

        // Select mode offers ready even without valid, and nothing loads
        s_select = 2'd2;
        #1;
        check_output("sel_ready_no_valid", 64'(s_oready), 64'b0100);
        apply_stimulus();
        check_output("sel_no_load", 64'(s_ovalid), 64'd0);

        // N=3: out-of-range select grants nobody while the output still drains
        t_iready  = 1'b1;
        t_select  = 2'd1;
        t_valid   = 3'b111;
        t_data[1] = 64'hC1;
        push_odd(64'hC1, 2'd1);
        apply_stimulus();
        t_select = 2'd3;
        #1;
        check_output("odd_ready_oor", 64'(t_oready), 64'd0);
        apply_stimulus();
        check_output("odd_drained_oor", 64'(t_ovalid), 64'd0);
        t_select  = 2'd2;
        t_data[2] = 64'hC2;
        push_odd(64'hC2, 2'd2);
        apply_stimulus();
        t_valid = 3'b000;
        apply_stimulus();

        // Round-robin fairness: all four valid for eight transfers
        r_iready = 1'b1;
        r_valid  = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            check_output("rr_fair_grant", 64'(r_oready), 64'(4'b0001 << (c % 4)));
            push_rr(64'h1000 + 64'(c % 4), 2'(c % 4));
            apply_stimulus();
        end

        // Round-robin skip: channels 1 and 3 alternate, then 1 alone repeats
        r_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            push_rr(64'h1000 + 64'(((c % 2) == 0) ? 1 : 3), 2'(((c % 2) == 0) ? 1 : 3));
            apply_stimulus();
        end
        r_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            push_rr(64'h1001, 2'd1);
            apply_stimulus();
        end
        r_valid = 4'b0000;
        apply_stimulus();
        check_output("rr_drained", 64'(r_ovalid), 64'd0);

        // Stalled cycles must not move the pointer (last winner was 1, so 2 then 3)
        r_iready = 1'b0;
        r_valid  = 4'hF;
        push_rr(64'h1002, 2'd2);
        apply_stimulus();
        for (int c = 0; c < 2; c++) begin
            #1;
            check_output("rr_stall_ready", 64'(r_oready), 64'd0);
            apply_stimulus();
        end
        r_iready = 1'b1;
        #1;
        check_output("rr_after_stall", 64'(r_oready), 64'b1000);
        push_rr(64'h1003, 2'd3);
        apply_stimulus();
        r_valid = 4'b0000;
        apply_stimulus();

        // Mid-stream reset while full: held word is discarded at once
        r_iready = 1'b0;
        r_valid  = 4'hF;
        apply_stimulus();
        check_output("rr_full_before_rst", 64'(r_ovalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rr_async_clear", 64'(r_ovalid), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        r_iready = 1'b1;
        #1;
        check_output("rr_ptr_after_rst", 64'(r_oready), 64'b0001);
        push_rr(64'h1000, 2'd0);
        apply_stimulus();
        r_valid = 4'b0000;
        apply_stimulus();
        check_output("rr_final_drain", 64'(r_ovalid), 64'd0);

        check_output("sel_queue_left", 64'(q_sel.size()), 64'd0);
        check_output("rr_queue_left", 64'(q_rr.size()), 64'd0);
        check_output("odd_queue_left", 64'(q_odd.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
